// File: rtl/io_input_ctrl.sv
// io_input_ctrl: synchronize, debounce and snapshot the nine connector inputs.
// Ports: CLK, RST_N (async, active low); IO_IN[8:0] raw pins;
//   SNAP_REQ/SNAP_ACK/SNAP_DATA four-phase snapshot read;
//   CHG_IRQ sticky change flag, cleared by IRQ_CLR edge;
//   IO678_OUT = debounced IO6 & IO7 & IO8.
module io_input_ctrl #(
  parameter int PRESCALE   = 100,
  parameter int DEB_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [8:0] IO_IN,
  input  logic       SNAP_REQ,
  output logic       SNAP_ACK,
  output logic [8:0] SNAP_DATA,
  output logic       CHG_IRQ,
  input  logic       IRQ_CLR,
  output logic       IO678_OUT
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACK   = 2'd2
  } state_e;

  logic [8:0]    io_s1_q, io_s2_q;
  logic          req_s1_q, req_s2_q;
  logic          clr_s1_q, clr_s2_q;
  logic [1:0]    vld_q;
  logic          req_prev_q, req_prev_d;
  logic          clr_prev_q, clr_prev_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [8:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [9];
  logic [CW-1:0] cnt_d [9];
  logic          chg;
  logic          req_rise, clr_rise;
  logic          irq_q, irq_d;
  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic [8:0]    data_q, data_d;

  // Synchronizers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      io_s1_q  <= '0;
      io_s2_q  <= '0;
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
      vld_q    <= '0;
    end else begin
      io_s1_q  <= IO_IN;
      io_s2_q  <= io_s1_q;
      req_s1_q <= SNAP_REQ;
      req_s2_q <= req_s1_q;
      clr_s1_q <= IRQ_CLR;
      clr_s2_q <= clr_s1_q;
      vld_q    <= {vld_q[0], 1'b1};
    end
  end

  // The sync flops restart at 0, so a level held across reset would
  // look like a fresh edge once it propagates. Keep the edge history
  // pinned high until the synchronizers carry real pin values.
  assign req_prev_d = vld_q[1] ? req_s2_q : 1'b1;
  assign clr_prev_d = vld_q[1] ? clr_s2_q : 1'b1;
  assign req_rise   = req_s2_q & ~req_prev_q;
  assign clr_rise   = clr_s2_q & ~clr_prev_q;

  // Sample-tick prescaler.
  assign tick  = (pre_q == PMAX);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // Debounce: accept a new level after DEB_CYCLES differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 9; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (tick) begin
      for (int i = 0; i < 9; i++) begin
        if (io_s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CMAX) begin
          stable_d[i] = io_s2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign chg   = |(stable_d ^ stable_q);
  // A set in the same cycle as a clear wins.
  assign irq_d = chg | (irq_q & ~clr_rise);

  // Snapshot handshake.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_rise) state_d = LATCH;
      end
      LATCH: begin
        data_d  = stable_q;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        if (!req_s2_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
      pre_q      <= '0;
      stable_q   <= '0;
      for (int i = 0; i < 9; i++) begin
        cnt_q[i] <= '0;
      end
      irq_q      <= 1'b0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      req_prev_q <= req_prev_d;
      clr_prev_q <= clr_prev_d;
      pre_q      <= pre_d;
      stable_q   <= stable_d;
      for (int i = 0; i < 9; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      irq_q      <= irq_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
    end
  end

  assign SNAP_ACK  = ack_q;
  assign SNAP_DATA = data_q;
  assign CHG_IRQ   = irq_q;
  assign IO678_OUT = &stable_q[8:6];

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed bench for io_input_ctrl.
// PRESCALE=4, DEB_CYCLES=3; inputs driven and outputs sampled 1ns after CLK rise.
module tb_io_input_ctrl;

  localparam int P = 4;
  localparam int D = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] io    = '0;
  logic       req   = 1'b0;
  logic       clr   = 1'b0;
  logic       ack;
  logic [8:0] data;
  logic       irq;
  logic       io678;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  io_input_ctrl #(
    .PRESCALE  (P),
    .DEB_CYCLES(D)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .IO_IN    (io),
    .SNAP_REQ (req),
    .SNAP_ACK (ack),
    .SNAP_DATA(data),
    .CHG_IRQ  (irq),
    .IRQ_CLR  (clr),
    .IO678_OUT(io678)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic snapshot(output logic [8:0] d);
    int t;
    req = 1'b1;
    t = 0;
    while (ack !== 1'b1 && t < 10) begin
      step(1);
      t++;
    end
    vec++;
    if (ack !== 1'b1) begin
      err++;
      $display("FAIL snap_ack_rise got=%b want=1", ack);
    end
    d = data;
    req = 1'b0;
    t = 0;
    while (ack !== 1'b0 && t < 10) begin
      step(1);
      t++;
    end
    vec++;
    if (ack !== 1'b0) begin
      err++;
      $display("FAIL snap_ack_fall got=%b want=0", ack);
    end
    step(1);
  endtask

  task automatic clear_irq();
    clr = 1'b1;
    step(3);
    clr = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    logic [8:0] d;
    int first_io, first_irq;
    rst_n = 1'b0;
    io    = 9'h1FF;
    step(3);
    vec++;
    if (ack !== 1'b0) begin
      err++; $display("FAIL rst_ack got=%b want=0", ack);
    end
    vec++;
    if (data !== 9'h000) begin
      err++; $display("FAIL rst_data got=%h want=000", data);
    end
    vec++;
    if (irq !== 1'b0) begin
      err++; $display("FAIL rst_irq got=%b want=0", irq);
    end
    vec++;
    if (io678 !== 1'b0) begin
      err++; $display("FAIL rst_io678 got=%b want=0", io678);
    end
    rst_n = 1'b1;
    first_io  = -1;
    first_irq = -1;
    for (int e = 1; e <= 30; e++) begin
      step(1);
      if (io678 === 1'b1 && first_io < 0) first_io = e;
      if (irq === 1'b1 && first_irq < 0) first_irq = e;
    end
    // 2 sync edges, then the first of D samples may land one cycle
    // later; worst case a full extra tick period on top of D periods.
    vec++;
    if (first_io < 2 + (D - 1) * P + 1 || first_io > 2 + (D + 1) * P) begin
      err++;
      $display("FAIL boot_latency got=%0d want=%0d..%0d",
               first_io, 2 + (D - 1) * P + 1, 2 + (D + 1) * P);
    end
    vec++;
    if (first_irq !== first_io) begin
      err++;
      $display("FAIL boot_irq_edge got=%0d want=%0d", first_irq, first_io);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h1FF) begin
      err++; $display("FAIL boot_stable got=%h want=1ff", d);
    end
    clr = 1'b1;
    step(2);
    vec++;
    if (irq !== 1'b1) begin
      err++; $display("FAIL clr_early got=%b want=1", irq);
    end
    step(1);
    vec++;
    if (irq !== 1'b0) begin
      err++; $display("FAIL clr_3edge got=%b want=0", irq);
    end
    clr = 1'b0;
    step(3);
  endtask

  task automatic test_bounce();
    logic [8:0] d;
    int hits, t;
    io = 9'h000;
    step(20);
    clear_irq();
    vec++;
    if (irq !== 1'b0) begin
      err++; $display("FAIL bounce_pre_irq got=%b want=0", irq);
    end
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      io[3] = 1'b1;
      step(1);
      io[3] = 1'b0;
      for (int j = 0; j < 5; j++) begin
        step(1);
        if (irq !== 1'b0) hits++;
      end
    end
    step(6);
    vec++;
    if (hits != 0 || irq !== 1'b0) begin
      err++; $display("FAIL bounce_irq got=%0d want=0", hits);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h000) begin
      err++; $display("FAIL bounce_stable got=%h want=000", d);
    end
    io[3] = 1'b1;
    t = 0;
    while (irq !== 1'b1 && t < 25) begin
      step(1);
      t++;
    end
    vec++;
    if (t > 2 + 16) begin
      err++; $display("FAIL hold_latency got=%0d want<=18", t);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h008) begin
      err++; $display("FAIL hold_stable got=%h want=008", d);
    end
    clear_irq();
  endtask

  task automatic test_handshake();
    logic [8:0] d;
    int bad;
    io = 9'h0A5;
    step(20);
    clear_irq();
    req = 1'b1;
    step(3);
    vec++;
    if (ack !== 1'b0) begin
      err++; $display("FAIL hs_edge3 got=%b want=0", ack);
    end
    step(1);
    vec++;
    if (ack !== 1'b1) begin
      err++; $display("FAIL hs_edge4_ack got=%b want=1", ack);
    end
    vec++;
    if (data !== 9'h0A5) begin
      err++; $display("FAIL hs_edge4_data got=%h want=0a5", data);
    end
    io  = 9'h15A;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (data !== 9'h0A5 || ack !== 1'b1) bad++;
    end
    vec++;
    if (bad != 0) begin
      err++; $display("FAIL hs_hold got=%0d want=0", bad);
    end
    vec++;
    if (irq !== 1'b1) begin
      err++; $display("FAIL hs_irq got=%b want=1", irq);
    end
    req = 1'b0;
    step(2);
    vec++;
    if (ack !== 1'b1) begin
      err++; $display("FAIL hs_rel2 got=%b want=1", ack);
    end
    step(1);
    vec++;
    if (ack !== 1'b0) begin
      err++; $display("FAIL hs_rel3 got=%b want=0", ack);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h15A) begin
      err++; $display("FAIL hs_resnap got=%h want=15a", d);
    end
    clear_irq();
  endtask

  task automatic test_irq_collision();
    int t0, n;
    t0 = cyc;
    io[0] = 1'b1;
    n = 0;
    while (irq !== 1'b1 && n < 25) begin
      step(1);
      n++;
    end
    vec++;
    if (irq !== 1'b1) begin
      err++; $display("FAIL coll_probe got=%b want=1", irq);
    end
    clear_irq();
    // Restart at a whole number of tick periods so the update lands n
    // edges after the change again.
    while ((cyc - t0) % P != 0) step(1);
    io[0] = 1'b0;
    step(n - 3);
    clr = 1'b1;
    step(2);
    vec++;
    if (irq !== 1'b0) begin
      err++; $display("FAIL coll_pre got=%b want=0", irq);
    end
    step(1);
    vec++;
    if (irq !== 1'b1) begin
      err++; $display("FAIL coll_set_wins got=%b want=1", irq);
    end
    step(3);
    vec++;
    if (irq !== 1'b1) begin
      err++; $display("FAIL coll_held_clr got=%b want=1", irq);
    end
    clr = 1'b0;
    step(3);
    clr = 1'b1;
    step(3);
    vec++;
    if (irq !== 1'b0) begin
      err++; $display("FAIL coll_second_clr got=%b want=0", irq);
    end
    clr = 1'b0;
    step(3);
  endtask

  task automatic test_reset_mid();
    int bad;
    req = 1'b1;
    step(4);
    vec++;
    if (ack !== 1'b1) begin
      err++; $display("FAIL mid_ack_up got=%b want=1", ack);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (ack !== 1'b0) begin
      err++; $display("FAIL mid_async_drop got=%b want=0", ack);
    end
    step(3);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (ack !== 1'b0) bad++;
    end
    vec++;
    if (bad != 0) begin
      err++; $display("FAIL mid_no_reassert got=%0d want=0", bad);
    end
    req = 1'b0;
    step(3);
    req = 1'b1;
    step(3);
    vec++;
    if (ack !== 1'b0) begin
      err++; $display("FAIL mid_rereq3 got=%b want=0", ack);
    end
    step(1);
    vec++;
    if (ack !== 1'b1) begin
      err++; $display("FAIL mid_rereq4 got=%b want=1", ack);
    end
    req = 1'b0;
    step(4);
    step(20);
    clear_irq();
  endtask

  task automatic test_io678();
    logic [8:0] d;
    io = 9'h0C0;
    step(20);
    vec++;
    if (io678 !== 1'b0) begin
      err++; $display("FAIL io678_011 got=%b want=0", io678);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h0C0) begin
      err++; $display("FAIL io678_snap011 got=%h want=0c0", d);
    end
    io = 9'h1C0;
    step(2);
    vec++;
    if (io678 !== 1'b0) begin
      err++; $display("FAIL io678_early got=%b want=0", io678);
    end
    step(18);
    vec++;
    if (io678 !== 1'b1) begin
      err++; $display("FAIL io678_111 got=%b want=1", io678);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h1C0) begin
      err++; $display("FAIL io678_snap111 got=%h want=1c0", d);
    end
    io = 9'h140;
    step(20);
    vec++;
    if (io678 !== 1'b0) begin
      err++; $display("FAIL io678_101 got=%b want=0", io678);
    end
    snapshot(d);
    vec++;
    if (d !== 9'h140) begin
      err++; $display("FAIL io678_snap101 got=%h want=140", d);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_handshake();
    test_irq_collision();
    test_reset_mid();
    test_io678();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
